// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bundle: control inputs, instruction-memory port and IF/ID outputs.
// master = fetch stage, slave = surrounding datapath/memory/bench.
interface instruction_fetch_stage_if;
  logic        Start;
  logic        Halt;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Target;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] PC;
  logic [1:0]  State;
  logic [31:0] FetchCount;
  logic        MisalignedTarget;

  modport master (
    input  Start, Halt, Stall, Redirect, Target, Instruction,
    output Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           PC, State, FetchCount, MisalignedTarget
  );

  modport slave (
    output Start, Halt, Stall, Redirect, Target, Instruction,
    input  Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
           PC, State, FetchCount, MisalignedTarget
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// PC register and IF/ID pipeline register with start/halt sequencing,
// stall hold and redirect-with-flush in front of a combinational instruction memory.
//   state   | meaning
//   IDLE    | waiting for Start, IF/ID holds a bubble
//   RUN     | fetching; Halt > Redirect > Stall > sequential fetch
//   HALTED  | frozen until Reset, IF/ID holds a bubble
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input logic                       Clk,
  input logic                       Reset,
  instruction_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcplus4_q, pcplus4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        misaligned_q, misaligned_d;
  logic [31:0] pc_next_seq;

  assign pc_next_seq = pc_q + PC_STEP;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pcplus4_q    <= '0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pcplus4_q    <= pcplus4_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pcplus4_d    = pcplus4_q;
    valid_d      = valid_q;
    count_d      = count_q;
    misaligned_d = misaligned_q;
    unique case (state_q)
      IDLE: begin
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
        if (bus.Start) state_d = RUN;
      end
      RUN: begin
        if (bus.Halt) begin
          state_d   = HALTED;
          instr_d   = '0;
          pcplus4_d = '0;
          valid_d   = 1'b0;
        end else if (bus.Redirect) begin
          // Redirect outranks Stall so the wrong-path fetch is always flushed.
          pc_d      = {bus.Target[31:2], 2'b00};
          instr_d   = '0;
          pcplus4_d = '0;
          valid_d   = 1'b0;
          if (bus.Target[1:0] != 2'b00) misaligned_d = 1'b1;
        end else if (!bus.Stall) begin
          instr_d   = bus.Instruction;
          pcplus4_d = pc_next_seq;
          valid_d   = 1'b1;
          pc_d      = pc_next_seq;
          count_d   = count_q + 32'd1;
        end
      end
      HALTED: begin
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        instr_d   = '0;
        pcplus4_d = '0;
        valid_d   = 1'b0;
      end
    endcase
  end

  assign bus.Address          = pc_q;
  assign bus.PC               = pc_q;
  assign bus.IFID_Instruction = instr_q;
  assign bus.IFID_PCPlus4     = pcplus4_q;
  assign bus.IFID_Valid       = valid_q;
  assign bus.State            = state_q;
  assign bus.FetchCount       = count_q;
  assign bus.MisalignedTarget = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed plus randomized bench for instruction_fetch_stage against a
// cycle-level behavioural model; instruction memory word i holds 3*i.
module tb_instruction_fetch_stage;
  logic Clk;
  logic Reset;
  instruction_fetch_stage_if bus();

  instruction_fetch_stage #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  logic [31:0] mem [128];
  assign bus.Instruction = mem[bus.Address[8:2]];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // reference model: 0 idle, 1 run, 2 halted
  int          m_state;
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  logic        m_valid, m_mis;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'd3 * ((addr / 32'd4) % 32'd128);
  endfunction

  task automatic model_reset();
    m_state = 0; m_pc = 0; m_instr = 0; m_pp4 = 0; m_cnt = 0;
    m_valid = 0; m_mis = 0;
  endtask

  task automatic bubble();
    m_instr = 0; m_pp4 = 0; m_valid = 0;
  endtask

  task automatic model_step();
    if (m_state == 0) begin
      bubble();
      if (bus.Start) m_state = 1;
    end else if (m_state == 2) begin
      bubble();
    end else if (bus.Halt) begin
      m_state = 2;
      bubble();
    end else if (bus.Redirect) begin
      m_pc = bus.Target - (bus.Target % 32'd4);
      if (bus.Target % 32'd4 != 0) m_mis = 1;
      bubble();
    end else if (!bus.Stall) begin
      m_instr = word_at(m_pc);
      m_pp4   = m_pc + 32'd4;
      m_valid = 1;
      m_pc    = m_pc + 32'd4;
      m_cnt   = m_cnt + 32'd1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state", {30'd0, bus.State}, m_state);
    chk("pc", bus.PC, m_pc);
    chk("address", bus.Address, m_pc);
    chk("valid", {31'd0, bus.IFID_Valid}, {31'd0, m_valid});
    chk("instr", bus.IFID_Instruction, m_instr);
    if (m_valid) chk("pcplus4", bus.IFID_PCPlus4, m_pp4);
    chk("count", bus.FetchCount, m_cnt);
    chk("misaligned", {31'd0, bus.MisalignedTarget}, {31'd0, m_mis});
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 Reset = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.Start = 0; bus.Halt = 0; bus.Stall = 0; bus.Redirect = 0; bus.Target = 0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    bus.Redirect = 1; bus.Target = t;
    tick();
    bus.Redirect = 0; bus.Target = 0;
  endtask

  task automatic start_run();
    bus.Start = 1;
    tick();
    bus.Start = 0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd3 * i;
    clear_inputs();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    check_all();

    // Start together with Reset: Reset wins
    bus.Start = 1;
    @(posedge Clk);
    #1;
    check_all();
    chk("start_during_reset", {30'd0, bus.State}, 32'd0);
    Reset = 0; bus.Start = 0;

    // free run from reset
    start_run();
    repeat (4) tick();
    chk("run4_instr", bus.IFID_Instruction, 32'd9);
    chk("run4_pp4", bus.IFID_PCPlus4, 32'd16);
    chk("run4_count", bus.FetchCount, 32'd4);
    chk("run4_pc", bus.PC, 32'd16);

    // stall hold at PC=8
    mid_reset();
    start_run();
    repeat (2) tick();
    bus.Stall = 1;
    repeat (2) tick();
    chk("stall_pc", bus.PC, 32'd8);
    chk("stall_instr", bus.IFID_Instruction, 32'd3);
    bus.Stall = 0;
    tick();
    chk("stall_release", bus.IFID_Instruction, 32'd6);

    // redirect outranks stall
    bus.Stall = 1;
    redirect_to(32'h40);
    bus.Stall = 0;
    chk("redir_pc", bus.PC, 32'h40);
    chk("redir_bubble", {31'd0, bus.IFID_Valid}, 32'd0);
    tick();
    chk("redir_instr", bus.IFID_Instruction, 32'd48);
    chk("redir_pp4", bus.IFID_PCPlus4, 32'h44);

    // misaligned target is sticky
    redirect_to(32'h43);
    chk("mis_pc", bus.PC, 32'h40);
    repeat (3) tick();
    chk("mis_sticky", {31'd0, bus.MisalignedTarget}, 32'd1);

    // memory index wrap past 0x1FC
    redirect_to(32'h1F8);
    tick();
    chk("wrap_378", bus.IFID_Instruction, 32'd378);
    tick();
    chk("wrap_381", bus.IFID_Instruction, 32'd381);
    chk("wrap_pc", bus.PC, 32'h200);
    tick();
    chk("wrap_word0", bus.IFID_Instruction, 32'd0);

    // redirect to the current PC refetches the same address
    redirect_to(bus.PC);
    chk("self_redir_pc", bus.PC, 32'h204);
    tick();
    chk("self_redir_instr", bus.IFID_Instruction, 32'd3);

    // 32-bit PC wrap
    redirect_to(32'hFFFF_FFFC);
    tick();
    chk("pc_wrap_instr", bus.IFID_Instruction, 32'd381);
    chk("pc_wrap_pc", bus.PC, 32'd0);

    // halt at PC=20, then everything but Reset is ignored
    redirect_to(32'd20);
    bus.Halt = 1;
    tick();
    bus.Halt = 0;
    chk("halt_state", {30'd0, bus.State}, 32'd2);
    chk("halt_pc", bus.PC, 32'd20);
    start_run();
    bus.Stall = 1;
    redirect_to(32'h80);
    bus.Stall = 0;
    tick();
    chk("halt_frozen_pc", bus.PC, 32'd20);
    chk("halt_frozen_state", {30'd0, bus.State}, 32'd2);
    mid_reset();
    chk("async_rst_state", {30'd0, bus.State}, 32'd0);
    chk("async_rst_pc", bus.PC, 32'd0);
    chk("async_rst_mis", {31'd0, bus.MisalignedTarget}, 32'd0);

    // IDLE ignores Halt/Stall/Redirect
    bus.Halt = 1; bus.Stall = 1;
    redirect_to(32'h100);
    clear_inputs();
    chk("idle_ignore_pc", bus.PC, 32'd0);

    // randomized phase
    for (int c = 0; c < 600; c++) begin
      bus.Start    = ($urandom_range(0, 3) == 0);
      bus.Halt     = ($urandom_range(0, 49) == 0);
      bus.Stall    = ($urandom_range(0, 3) == 0);
      bus.Redirect = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: bus.Target = $urandom_range(0, 1023);
        1: bus.Target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: bus.Target = $urandom_range(0, 255) * 4;
      endcase
      tick();
      if ($urandom_range(0, 59) == 0) mid_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- PC and IF/ID front end of the pipelined datapath. Sits directly upstream of the 128-word instruction memory.
- Drives the memory's 32-bit byte address from the PC and captures the returned word into the IF/ID pipeline register.
- Handles start/halt sequencing, stall, and branch/jump redirect with flush.
- Memory read is combinational: Instruction is valid in the same cycle Address is driven.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle pulse; begins fetching from IDLE
- Halt  input  1  level; stops fetching (from decode/control)
- Stall  input  1  hold PC and IF/ID contents (load-use hazard)
- Redirect  input  1  branch taken or jump resolved; load Target
- Target  input  32  redirect byte address
- Address  output  32  instruction memory address; equals PC combinationally
- Instruction  input  32  word returned by instruction memory for Address
- IFID_Instruction  output  32  registered instruction
- IFID_PCPlus4  output  32  registered PC+PC_STEP of that instruction
- IFID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble
- PC  output  32  current program counter
- State  output  2  00 IDLE, 01 RUN, 10 HALTED
- FetchCount  output  32  count of instructions latched with Valid=1
- MisalignedTarget  output  1  sticky; set when a redirect Target has bits[1:0] != 0

Behaviour:
- Reset, asynchronous and applicable at any time including mid-fetch, forces:
  - PC = RESET_PC, State = IDLE
  - IFID_Instruction = 0, IFID_PCPlus4 = 0, IFID_Valid = 0
  - FetchCount = 0, MisalignedTarget = 0
- Address = PC at all times. No additional latency: the word for PC is captured at the next rising edge.
- IDLE:
  - PC holds; IF/ID loads a bubble (Valid 0, instruction 0).
  - Start moves to RUN at the next edge. The first capture happens in the RUN cycle that follows, fetching RESET_PC.
  - Stall, Redirect and Halt are ignored.
- RUN, per rising edge, evaluated in priority order:
  1. Halt=1: move to HALTED. PC holds. IF/ID loads a bubble. The instruction at Address is not captured.
  2. Redirect=1, regardless of Stall: PC <= {Target[31:2], 2'b00}. IF/ID loads a bubble (flushes the wrong-path fetch). If Target[1:0] != 0, set MisalignedTarget.
  3. Stall=1: PC, IFID_Instruction, IFID_PCPlus4, IFID_Valid and FetchCount all hold.
  4. Otherwise:
     - IFID_Instruction <= Instruction
     - IFID_PCPlus4 <= PC + PC_STEP
     - IFID_Valid <= 1
     - PC <= PC + PC_STEP
     - FetchCount increments
- HALTED:
  - PC and FetchCount hold; IF/ID loads a bubble.
  - Only Reset exits. Start, Stall and Redirect are ignored.
- Arithmetic:
  - PC + PC_STEP is a 32-bit modulo add, wrapping 32'hFFFF_FFFC to 0.
  - The memory uses Address[8:2], so fetch wraps to word 0 after byte address 0x1FC. The stage does not detect this wrap.
  - FetchCount wraps modulo 2^32.
- Simultaneous Start with Reset: Reset wins.
- Redirect to the current PC is legal. It produces one bubble and a refetch of the same address.

Test Plan:
- Memory word i = 3*i; Reset, then Start, then 4 free-running cycles -> IFID_Instruction = 0, 3, 6, 9; IFID_PCPlus4 = 4, 8, 12, 16; FetchCount = 4; PC = 16.
- From PC=8, Stall high for 2 cycles -> PC stays 8, IFID_Instruction holds 3, FetchCount holds. On release, next capture is 6.
- At PC=12, Redirect with Target=0x40 and Stall=1 -> next edge: PC = 0x40, IFID_Valid = 0. Following edge: IFID_Instruction = 48, IFID_PCPlus4 = 0x44.
- Redirect with Target=0x43 -> PC = 0x40, MisalignedTarget = 1 and stays 1 through later normal fetches until Reset.
- Free-run from PC=0x1F8 -> captures 378, then 381, then PC=0x200 with Address[8:2]=0 captures 0.
- Halt asserted in RUN at PC=20 -> State = HALTED, PC = 20 frozen, IFID_Valid = 0; Start pulse ignored. Reset asserted between clock edges clears all outputs immediately and State = IDLE.
